instruction_memory: RTL and testbench

- 256 x 8-bit instruction store for the 8-bit single-cycle processor; fetch stage drives `pc`, block returns `instruction` combinationally in the same cycle.
- Asynchronous active-low reset loads a fixed boot program into the low addresses and clears the rest.
- Synchronous write port allows a loader or bench to overwrite the program after reset.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/instruction_memory.sv | 49 ++++
 tb/tb_instruction_memory.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction store: default geometry, NOP encoding
// and the boot program loaded on reset.
package imem_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 256;
  localparam int unsigned PROG_LEN   = 8;
  localparam int unsigned PROG_IDX_W = $clog2(PROG_LEN);

  localparam logic [DATA_W-1:0] NOP = 8'h00;

  localparam logic [DATA_W-1:0] BOOT_PROG [PROG_LEN] = '{
    8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78
  };

  // Boot word for address idx; anything past the program is a NOP.
  function automatic logic [DATA_W-1:0] boot_word(input int unsigned idx);
    logic [PROG_IDX_W-1:0] sel;
    sel = PROG_IDX_W'(idx);
    return (idx < PROG_LEN) ? BOOT_PROG[sel] : NOP;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// 256 x 8 instruction store: combinational fetch port, synchronous write port,
// asynchronous active-low reset that reloads the boot program.
module instruction_memory #(
  parameter int unsigned ADDR_W   = imem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = imem_pkg::DATA_W,
  parameter int unsigned DEPTH    = imem_pkg::DEPTH,
  parameter int unsigned PROG_LEN = imem_pkg::PROG_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  import imem_pkg::*;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Reset is checked first, so a write edge coinciding with reset is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= (i < PROG_LEN) ? boot_word(i) : '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // No bypass: a same-address write shows up only after the clock edge.
  always_comb begin
    instruction = NOP;
    if (reset) begin
      instruction = mem_q[pc];
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed plus randomized checks of instruction_memory against an array model.
module tb_instruction_memory;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem  [256];
  logic [7:0] boot_ref [8] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78};

  instruction_memory #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .DEPTH   (256),
    .PROG_LEN(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instruction(instruction),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i < 8) ? boot_ref[i] : 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    return reset ? ref_mem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (reset) ref_mem[a] = d;
  endtask

  initial begin
    reset = 1'b0; pc = 8'h00; wr_en = 1'b1; wr_addr = 8'h00; wr_data = 8'hFF;
    model_reset();

    // Held in reset with an active write request: output stays NOP.
    for (int i = 0; i < 10; i++) begin
      #10;
      check("reset_hold", instruction, 8'h00);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1 reset = 1'b1;

    // Zero-latency fetch sweep; address 0 also proves the in-reset write was dropped.
    for (int i = 0; i < 20; i++) begin
      pc = 8'(i);
      #1 check($sformatf("sweep_pc%0d", i), instruction, model_read(pc));
      #4;
    end

    // Same-address write: old data before the edge, new after.
    @(negedge clk);
    pc = 8'h0A; wr_en = 1'b1; wr_addr = 8'h0A; wr_data = 8'hC3;
    #1 check("wr_before_edge", instruction, 8'h00);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ref_mem[8'h0A] = 8'hC3;
    check("wr_after_edge", instruction, 8'hC3);
    pc = 8'h09; #1 check("wr_neigh_09", instruction, model_read(pc));
    pc = 8'h0B; #1 check("wr_neigh_0b", instruction, model_read(pc));

    // Overwrite addr 0, then a short clockless reset pulse restores boot contents.
    write_word(8'h00, 8'hAA);
    pc = 8'h00; #1 check("ovr_addr0", instruction, 8'hAA);
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1 check("pulse_in_reset", instruction, 8'h00);
    reset = 1'b1;
    #1 check("pulse_after", instruction, 8'h01);
    pc = 8'h0A; #1 check("pulse_lost_0a", instruction, 8'h00);

    // pc wrap-around.
    pc = 8'hFF; #1 check("wrap_ff", instruction, model_read(pc));
    pc = pc + 8'h01; #1 check("wrap_00", instruction, 8'h01);
    write_word(8'hFF, 8'h5A);
    pc = 8'hFF; #1 check("wrap_wr_ff", instruction, 8'h5A);

    // Reset asserted on the same edge as a write: reset wins.
    @(negedge clk);
    pc = 8'h03; wr_en = 1'b1; wr_addr = 8'h03; wr_data = 8'hEE;
    @(posedge clk);
    reset = 1'b0;
    model_reset();
    #1 check("coinc_in_reset", instruction, 8'h00);
    wr_en = 1'b0;
    #2 reset = 1'b1;
    #1 check("coinc_after", instruction, 8'h34);

    // Randomized reads/writes with occasional resets.
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) begin
        #1 reset = 1'b0;
        model_reset();
        #1 check("rnd_in_reset", instruction, 8'h00);
        reset = 1'b1;
      end
      pc = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pc = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_addr = ($urandom_range(0, 2) == 0) ? pc : 8'($urandom);
        wr_data = 8'($urandom);
        #1 check("rnd_pre_edge", instruction, model_read(pc));
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ref_mem[wr_addr] = wr_data;
        check("rnd_post_edge", instruction, model_read(pc));
      end else begin
        #1 check("rnd_read", instruction, model_read(pc));
        @(posedge clk);
        #1 check("rnd_hold", instruction, model_read(pc));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
